// File: rtl/l1i_cache_param.sv
// Parametrised read-only set-associative L1 instruction cache with tree pseudo-LRU,
// flush-all and saturating hit/miss counters.
module l1i_cache_param #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 8,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  input  logic                 flush,
  input  logic                 hit_clear,
  input  logic                 miss_clear,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int unsigned OFF  = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - OFF - IDX;
  localparam int unsigned LVL  = $clog2(WAYS);
  localparam int unsigned WSW  = OFF - 2;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;
  logic   replay_q, replay_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [TAGW-1:0]      tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];

  logic [IDX-1:0]       set_idx;
  logic [TAGW-1:0]      tag;
  logic [WSW-1:0]       word_sel;
  logic                 hit;
  logic [LVL-1:0]       hit_way;
  logic [LVL-1:0]       victim;
  logic                 found;
  logic                 node_bit;
  int unsigned          node;
  logic [LINE_BITS-1:0] hit_line;

  logic           flush_all, fill_we, plru_we, hit_inc, miss_inc;
  logic [LVL-1:0] plru_way;
  logic           unused_addr;

  assign set_idx      = mem_address[OFF+IDX-1:OFF];
  assign tag          = mem_address[31:OFF+IDX];
  assign word_sel     = mem_address[OFF-1:2];
  assign pmem_address = {mem_address[31:OFF], {OFF{1'b0}}};
  assign unused_addr  = ^mem_address[1:0];
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  // Point every node on the path to `way` away from it (0 = lower half, 1 = upper half).
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] cur,
                                                 input logic [LVL-1:0]  way);
    logic [WAYS-2:0] r;
    logic [LVL-1:0]  tmp;
    logic            dir;
    int unsigned     n_idx;
    r     = cur;
    n_idx = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      tmp = way >> (LVL - 1 - l);
      dir = tmp[0];
      for (int unsigned n = 0; n < WAYS - 1; n++) begin
        if (n == n_idx) r[n] = ~dir;
      end
      n_idx = 2 * n_idx + 1 + 32'(dir);
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = LVL'(w);
      end
    end
    hit_line  = data_q[set_idx][hit_way];
    mem_rdata = hit_line[{word_sel, 5'b0} +: 32];
  end

  // Lowest invalid way first; otherwise follow the PLRU tree from the root.
  always_comb begin
    victim   = '0;
    found    = 1'b0;
    node     = 0;
    node_bit = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[set_idx][w]) begin
        found  = 1'b1;
        victim = LVL'(w);
      end
    end
    if (!found) begin
      for (int unsigned l = 0; l < LVL; l++) begin
        node_bit = 1'b0;
        for (int unsigned n = 0; n < WAYS - 1; n++) begin
          if (n == node) node_bit = plru_q[set_idx][n];
        end
        node = 2 * node + 1 + 32'(node_bit);
      end
      victim = LVL'(node - (WAYS - 1));
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    replay_d     = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    flush_all    = 1'b0;
    fill_we      = 1'b0;
    plru_we      = 1'b0;
    plru_way     = hit_way;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state_q)
      StIdle: begin
        // A pending flush from a fill takes effect here, ahead of the lookup.
        if (flush || flush_pend_q) begin
          flush_all    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (mem_read) begin
          if (hit) begin
            mem_resp = 1'b1;
            plru_we  = 1'b1;
            hit_inc  = ~replay_q;
          end else begin
            state_d  = StFetch;
            miss_inc = 1'b1;
          end
        end
      end
      StFetch: begin
        pmem_read = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (pmem_resp) begin
          fill_we  = 1'b1;
          plru_we  = 1'b1;
          plru_way = victim;
          replay_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_clear)                     hit_d = '0;
    else if (hit_inc && hit_q != '1)   hit_d = hit_q + 32'd1;
    if (miss_clear)                    miss_d = '0;
    else if (miss_inc && miss_q != '1) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      replay_q     <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      replay_q     <= replay_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      if (flush_all) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (fill_we) valid_q[set_idx][victim] <= 1'b1;
      if (plru_we) plru_q[set_idx] <= plru_touch(plru_q[set_idx], plru_way);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[set_idx][victim] <= pmem_rdata;
      tag_q[set_idx][victim]  <= tag;
    end
  end

endmodule

// File: tb/tb_l1i_cache_param.sv
// Directed self-checking bench for l1i_cache_param: default 4-way instance plus a
// 2-way/4-set/128-bit instance for the address-split check.
module tb_l1i_cache_param;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  a_mem_address, a_mem_rdata, a_pmem_address, a_hit_count, a_miss_count;
  logic         a_mem_read, a_mem_resp, a_pmem_read, a_pmem_resp;
  logic         a_flush, a_hit_clear, a_miss_clear;
  logic [255:0] a_pmem_rdata;

  logic [31:0]  b_mem_address, b_mem_rdata, b_pmem_address, b_hit_count, b_miss_count;
  logic         b_mem_read, b_mem_resp, b_pmem_read, b_pmem_resp;
  logic         b_flush, b_hit_clear, b_miss_clear;
  logic [127:0] b_pmem_rdata;

  int checks   = 0;
  int failures = 0;
  bit plain    = 1'b1;

  l1i_cache_param dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (a_mem_address),
    .mem_read     (a_mem_read),
    .mem_rdata    (a_mem_rdata),
    .mem_resp     (a_mem_resp),
    .pmem_address (a_pmem_address),
    .pmem_read    (a_pmem_read),
    .pmem_rdata   (a_pmem_rdata),
    .pmem_resp    (a_pmem_resp),
    .flush        (a_flush),
    .hit_clear    (a_hit_clear),
    .miss_clear   (a_miss_clear),
    .hit_count    (a_hit_count),
    .miss_count   (a_miss_count)
  );

  l1i_cache_param #(
    .WAYS      (2),
    .SETS      (4),
    .LINE_BITS (128)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (b_mem_address),
    .mem_read     (b_mem_read),
    .mem_rdata    (b_mem_rdata),
    .mem_resp     (b_mem_resp),
    .pmem_address (b_pmem_address),
    .pmem_read    (b_pmem_read),
    .pmem_rdata   (b_pmem_rdata),
    .pmem_resp    (b_pmem_resp),
    .flush        (b_flush),
    .hit_clear    (b_hit_clear),
    .miss_clear   (b_miss_clear),
    .hit_count    (b_hit_count),
    .miss_count   (b_miss_count)
  );

  // Word i of a fill line is i, or {line address[23:0], i} when tagged.
  function automatic logic [255:0] line_of(input logic [31:0] addr);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = plain ? 32'(i) : {addr[23:0], 8'(i)};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    int cnt;
    a_pmem_resp  = 1'b0;
    a_pmem_rdata = '0;
    cnt          = 0;
    forever begin
      @(negedge clk);
      cnt          = a_pmem_read ? cnt + 1 : 0;
      a_pmem_resp  = (cnt == LAT);
      a_pmem_rdata = line_of(a_pmem_address);
    end
  end

  initial begin
    int cnt;
    logic [255:0] l;
    b_pmem_resp  = 1'b0;
    b_pmem_rdata = '0;
    cnt          = 0;
    forever begin
      @(negedge clk);
      cnt          = b_pmem_read ? cnt + 1 : 0;
      b_pmem_resp  = (cnt == LAT);
      l            = line_of(b_pmem_address);
      b_pmem_rdata = l[127:0];
    end
  end

  // Issue one read and hold it until mem_resp; optionally pulse flush in a given fill cycle.
  task automatic rd(input bit sel, input logic [31:0] addr, input int exp_fills,
                    input logic [31:0] exp_faddr, input logic [31:0] exp_data,
                    input int flush_at, input string tag);
    int cyc, fills, fcyc, presp_cyc, resp_cyc;
    bit prev_pr, done, pr, rsp, presp;
    logic [31:0] pa, rdat;
    cyc = 0; fills = 0; fcyc = 0; presp_cyc = -10; resp_cyc = -1;
    prev_pr = 1'b0; done = 1'b0;
    @(negedge clk);
    if (sel) begin b_mem_address = addr; b_mem_read = 1'b1; end
    else     begin a_mem_address = addr; a_mem_read = 1'b1; end
    while (!done && cyc < 100) begin
      #2;
      pr    = sel ? b_pmem_read    : a_pmem_read;
      pa    = sel ? b_pmem_address : a_pmem_address;
      rsp   = sel ? b_mem_resp     : a_mem_resp;
      rdat  = sel ? b_mem_rdata    : a_mem_rdata;
      presp = sel ? b_pmem_resp    : a_pmem_resp;
      if (pr && !prev_pr) begin
        fills++;
        chk({tag, " faddr"}, pa, exp_faddr);
      end
      if (pr) fcyc++;
      if (presp) presp_cyc = cyc;
      prev_pr = pr;
      if (rsp) begin
        done     = 1'b1;
        resp_cyc = cyc;
        chk({tag, " rdata"}, rdat, exp_data);
      end else begin
        @(negedge clk);
        cyc++;
        if (!sel) a_flush = (flush_at > 0) && (fills == 1) && prev_pr && (fcyc == flush_at - 1);
      end
    end
    chk({tag, " resp"}, 32'(done), 32'd1);
    chk({tag, " fills"}, fills, exp_fills);
    if (exp_fills == 0) chk({tag, " lat"}, resp_cyc, 0);
    else                chk({tag, " lat"}, resp_cyc - presp_cyc, 1);
    @(negedge clk);
    a_flush = 1'b0;
    if (sel) b_mem_read = 1'b0;
    else     a_mem_read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0;
    a_mem_address = '0; a_mem_read = 1'b0; a_flush = 1'b0;
    a_hit_clear   = 1'b0; a_miss_clear = 1'b0;
    b_mem_address = '0; b_mem_read = 1'b0; b_flush = 1'b0;
    b_hit_clear   = 1'b0; b_miss_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst pmem_read", 32'(a_pmem_read), 0);
    chk("rst hit", a_hit_count, 0);
    chk("rst miss", a_miss_count, 0);
    chk("rst b miss", b_miss_count, 0);

    // Basic miss then hit, fill word i = i.
    plain = 1'b1;
    rd(1'b0, 32'h44, 1, 32'h40, 32'd1, 0, "t1 0x44");
    chk("t1 miss", a_miss_count, 1);
    chk("t1 hit0", a_hit_count, 0);
    rd(1'b0, 32'h48, 0, 32'h0, 32'd2, 0, "t1 0x48");
    chk("t1 hit1", a_hit_count, 1);

    // PLRU replacement in set 0.
    plain = 1'b0;
    do_reset();
    rd(1'b0, 32'h000, 1, 32'h000, 32'h0000_0000, 0, "t2 f0");
    rd(1'b0, 32'h100, 1, 32'h100, 32'h0001_0000, 0, "t2 f1");
    rd(1'b0, 32'h200, 1, 32'h200, 32'h0002_0000, 0, "t2 f2");
    rd(1'b0, 32'h300, 1, 32'h300, 32'h0003_0000, 0, "t2 f3");
    rd(1'b0, 32'h000, 0, 32'h0,   32'h0000_0000, 0, "t2 h0");
    rd(1'b0, 32'h400, 1, 32'h400, 32'h0004_0000, 0, "t2 f4");
    rd(1'b0, 32'h100, 0, 32'h0,   32'h0001_0000, 0, "t2 h1");
    rd(1'b0, 32'h30C, 0, 32'h0,   32'h0003_0003, 0, "t2 h3");
    rd(1'b0, 32'h200, 1, 32'h200, 32'h0002_0000, 0, "t2 f2b");
    chk("t2 miss", a_miss_count, 6);
    chk("t2 hit", a_hit_count, 3);
    @(negedge clk); a_miss_clear = 1'b1;
    @(negedge clk); a_miss_clear = 1'b0;
    #2;
    chk("t2 mclr", a_miss_count, 0);
    chk("t2 mclr hit", a_hit_count, 3);

    // Flush during the second fill cycle forces a refetch.
    do_reset();
    rd(1'b0, 32'h80, 2, 32'h80, 32'h0000_8000, 2, "t3 flush");
    chk("t3 miss", a_miss_count, 2);
    chk("t3 hit", a_hit_count, 0);

    // Reset mid-fill.
    @(negedge clk);
    a_mem_address = 32'h1000;
    a_mem_read    = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      #2;
      seen = a_pmem_read;
      if (!seen) begin @(negedge clk); n++; end
    end
    chk("t4 fetch", 32'(seen), 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; a_mem_read = 1'b0;
    #2;
    chk("t4 pmem_read", 32'(a_pmem_read), 0);
    chk("t4 miss", a_miss_count, 0);
    chk("t4 hit", a_hit_count, 0);
    rd(1'b0, 32'h80, 1, 32'h80, 32'h0000_8000, 0, "t4 refetch");
    chk("t4 miss1", a_miss_count, 1);

    // Hit counter saturation and clear-wins.
    @(negedge clk);
    force dut_a.hit_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_a.hit_q;
    #2;
    chk("t5 forced", a_hit_count, 32'hFFFF_FFFE);
    rd(1'b0, 32'h80, 0, 32'h0, 32'h0000_8000, 0, "t5 h1");
    chk("t5 cnt1", a_hit_count, 32'hFFFF_FFFF);
    rd(1'b0, 32'h80, 0, 32'h0, 32'h0000_8000, 0, "t5 h2");
    rd(1'b0, 32'h80, 0, 32'h0, 32'h0000_8000, 0, "t5 h3");
    chk("t5 sat", a_hit_count, 32'hFFFF_FFFF);
    @(negedge clk);
    a_hit_clear   = 1'b1;
    a_mem_address = 32'h80;
    a_mem_read    = 1'b1;
    #2;
    chk("t5 clr resp", 32'(a_mem_resp), 1);
    @(negedge clk);
    a_hit_clear = 1'b0;
    a_mem_read  = 1'b0;
    #2;
    chk("t5 clr", a_hit_count, 0);

    // 2-way, 4 sets, 128-bit lines: OFF=4, IDX=2.
    rd(1'b1, 32'h1C, 1, 32'h10, 32'h0000_1003, 0, "t6 0x1C");
    rd(1'b1, 32'h2C, 1, 32'h20, 32'h0000_2003, 0, "t6 0x2C");
    rd(1'b1, 32'h1C, 0, 32'h0,  32'h0000_1003, 0, "t6 0x1C hit");
    chk("t6 miss", b_miss_count, 2);
    chk("t6 hit", b_hit_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
